// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the iterative multiply/divide unit.
// Function codes as driven by the microcode sequencer.
// FSM state encoding shared by the top level and any observers.
package muldiv_seq_pkg;

  localparam logic [1:0] MD_MUL  = 2'd0;
  localparam logic [1:0] MD_IMUL = 2'd1;
  localparam logic [1:0] MD_DIV  = 2'd2;
  localparam logic [1:0] MD_IDIV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration shared by multiply (shift-add) and divide (restoring).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module muldiv_step #(
  parameter int W = 16
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  input  logic           in_bit,
  input  logic           div_mode,
  output logic [2*W-1:0] acc_nxt,
  output logic           q_bit
);

  // Partial remainder shifted left with the next dividend bit appended.
  logic [W:0] trial;
  logic [W:0] diff;

  assign trial = {acc[W-1:0], in_bit};
  assign diff  = trial - {1'b0, operand};

  // Divide: keep the difference when it does not go negative; multiply:
  // double the accumulator and add the multiplicand when the multiplier bit is set.
  always_comb begin
    acc_nxt = '0;
    q_bit   = 1'b0;
    if (div_mode) begin
      if (trial >= {1'b0, operand}) begin
        acc_nxt = {{(W-1){1'b0}}, diff};
        q_bit   = 1'b1;
      end else begin
        acc_nxt = {{(W-1){1'b0}}, trial};
      end
    end else begin
      acc_nxt = {acc[2*W-2:0], 1'b0} + (in_bit ? {{W{1'b0}}, operand} : {(2*W){1'b0}});
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential MUL/IMUL/DIV/IDIV unit, byte or word operands, one bit per clock.
// Latency: done in cycle N+2 after the start edge; early divide error in cycle 2.
// Backpressure: start is sampled only while idle; start while busy is dropped.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     func,
  input  logic           word_op,
  input  logic [2*W-1:0] x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] out,
  output logic           cfo,
  output logic           ofo,
  output logic           div_exc
);

  localparam int H  = W / 2;
  localparam int CW = $clog2(W + 1);

  // Keep only the low N bits of a W-bit value.
  function automatic logic [W-1:0] mask_n(input logic [W-1:0] v, input logic wd);
    return wd ? v : {{H{1'b0}}, v[H-1:0]};
  endfunction

  // Keep only the low 2N bits of a 2W-bit value.
  function automatic logic [2*W-1:0] mask_2n(input logic [2*W-1:0] v, input logic wd);
    return wd ? v : {{W{1'b0}}, v[W-1:0]};
  endfunction

  md_state_t      state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [1:0]     func_q;
  logic           word_q;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_src;
  logic [2*W-1:0] acc;
  logic [W-1:0]   q;
  logic           sign_q;
  logic           sign_r;
  logic           exc_q;

  // ---- operand preparation, evaluated while idle ----
  logic           is_signed, is_div;
  logic [W-1:0]   y_n, y_mag, xm_n, xm_mag, x_hi, x_lo;
  logic [2*W-1:0] xd_n, xd_mag;
  logic           sy, sxm, sxd, sx, early_exc;

  assign is_signed = (func == MD_IMUL) || (func == MD_IDIV);
  assign is_div    = func[1];

  assign y_n   = mask_n(y, word_op);
  assign sy    = word_op ? y[W-1] : y[H-1];
  assign y_mag = (is_signed && sy) ? mask_n(-y_n, word_op) : y_n;

  assign xm_n   = mask_n(x[W-1:0], word_op);
  assign sxm    = word_op ? x[W-1] : x[H-1];
  assign xm_mag = (is_signed && sxm) ? mask_n(-xm_n, word_op) : xm_n;

  assign xd_n   = mask_2n(x, word_op);
  assign sxd    = word_op ? x[2*W-1] : x[W-1];
  assign xd_mag = (is_signed && sxd) ? mask_2n(-xd_n, word_op) : xd_n;
  assign x_hi   = word_op ? xd_mag[2*W-1:W] : {{H{1'b0}}, xd_mag[W-1:H]};
  assign x_lo   = word_op ? xd_mag[W-1:0]   : {{H{1'b0}}, xd_mag[H-1:0]};

  assign sx        = is_div ? sxd : sxm;
  // Quotient would not fit in N bits (or divisor is zero): fault before iterating.
  assign early_exc = is_div && ((y_mag == '0) || (x_hi >= y_mag));

  // ---- shared iteration ----
  logic [2*W-1:0] step_acc;
  logic           step_q;
  logic           step_bit;

  // Multiplier / dividend-low bits are consumed MSB-first from bit N-1.
  assign step_bit = word_q ? b_src[W-1] : b_src[H-1];

  muldiv_step #(.W(W)) u_step (
    .acc      (acc),
    .operand  (a_mag),
    .in_bit   (step_bit),
    .div_mode (func_q[1]),
    .acc_nxt  (step_acc),
    .q_bit    (step_q)
  );

  // ---- result formatting for the FIX cycle ----
  logic [2*W-1:0] prod_s, div_out, res_out;
  logic [W-1:0]   prod_hi, prod_ext, q_s, r_s;
  logic           prod_msb, res_flag, res_exc, idiv_ovf;

  // Apply signs, derive flags and detect the IDIV range fault.
  always_comb begin
    prod_s   = sign_q ? mask_2n(-acc, word_q) : acc;
    prod_hi  = word_q ? prod_s[2*W-1:W] : {{H{1'b0}}, prod_s[W-1:H]};
    prod_msb = word_q ? prod_s[W-1] : prod_s[H-1];
    prod_ext = prod_msb ? mask_n({W{1'b1}}, word_q) : '0;
    q_s      = sign_q ? mask_n(-q, word_q) : q;
    r_s      = sign_r ? mask_n(-acc[W-1:0], word_q) : acc[W-1:0];
    div_out  = word_q ? {r_s, q_s} : {{W{1'b0}}, r_s[H-1:0], q_s[H-1:0]};
    // Magnitude >= 2^(N-1) faults for either sign, so -2^(N-1) traps like the 8086.
    idiv_ovf = (func_q == MD_IDIV) && (word_q ? q[W-1] : q[H-1]);
    res_exc  = exc_q || idiv_ovf;
    res_flag = 1'b0;
    res_out  = '0;
    if (!res_exc) begin
      if (func_q[1]) begin
        res_out = div_out;
      end else begin
        res_out  = prod_s;
        res_flag = (func_q == MD_IMUL) ? (prod_hi != prod_ext) : (prod_hi != '0);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and busy indication.
  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: if (start) state_nxt = early_exc ? ST_FIX : ST_CALC;
      ST_CALC: if (cnt == CW'(1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: latch operands on start, iterate in CALC, register results in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      func_q  <= '0;
      word_q  <= 1'b0;
      a_mag   <= '0;
      b_src   <= '0;
      acc     <= '0;
      q       <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      exc_q   <= 1'b0;
      done    <= 1'b0;
      out     <= '0;
      cfo     <= 1'b0;
      ofo     <= 1'b0;
      div_exc <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            func_q <= func;
            word_q <= word_op;
            sign_q <= is_signed && (sx ^ sy);
            sign_r <= is_signed && sx;
            exc_q  <= early_exc;
            cnt    <= word_op ? CW'(W) : CW'(H);
            q      <= '0;
            if (is_div) begin
              a_mag <= y_mag;
              b_src <= x_lo;
              acc   <= {{W{1'b0}}, x_hi};
            end else begin
              a_mag <= xm_mag;
              b_src <= y_mag;
              acc   <= '0;
            end
          end
        end
        ST_CALC: begin
          acc   <= step_acc;
          q     <= {q[W-2:0], step_q};
          b_src <= {b_src[W-2:0], 1'b0};
          cnt   <= cnt - CW'(1);
        end
        ST_FIX: begin
          done    <= 1'b1;
          out     <= res_out;
          cfo     <= res_flag;
          ofo     <= res_flag;
          div_exc <= res_exc;
        end
        default: ;
      endcase
    end
  end

endmodule
